// File: rtl/rt_tx_responder.sv
// -----------------------------------------------------------------------------
// rt_tx_responder
//
// Remote-terminal transmit responder for an MKIO (GOST 26765.52) channel.
// When the command decoder reports a transmit command addressed to this
// terminal, the block sends the status word and then N data words to the
// Manchester encoder, one word per encoder handshake
// (tx_ready strobe -> tx_done pulse). The data words come from a 32x16
// buffer that the host fills through its own write port.
//
// Parameters
//   ADDRESS  terminal address, placed in status word bits [15:11]
//   TIMEOUT  max clk cycles to wait for tx_done on each word
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        asynchronous, active-high
//   start        1-cycle pulse: transmit command for this terminal decoded
//   cmd_word     command word, valid with start; [4:0] = count (0 means 32)
//   p_error      command word parity error, valid with start
//   tx_data      word handed to the encoder
//   tx_cd        sync type: 0 = status/command sync, 1 = data sync
//   tx_ready     1-cycle strobe: tx_data/tx_cd valid, encoder may start
//   tx_done      1-cycle pulse from the encoder: current word fully sent
//   wr_en        host buffer write enable
//   wr_addr      host buffer write address
//   wr_data      host buffer write data
//   busy         response in progress
//   words_sent   data words completed in the current/last response
//   timeout_err  sticky: encoder did not answer in time; cleared on next start
// -----------------------------------------------------------------------------
module rt_tx_responder #(
   parameter logic [4:0]  ADDRESS = 5'd1,
   parameter logic [15:0] TIMEOUT = 16'd2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] cmd_word,
   input  logic        p_error,
   output logic [15:0] tx_data,
   output logic        tx_cd,
   output logic        tx_ready,
   input  logic        tx_done,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [15:0] wr_data,
   output logic        busy,
   output logic [5:0]  words_sent,
   output logic        timeout_err
);

   // -------------------------------------------------------------------------
   // Sequencer states
   // -------------------------------------------------------------------------
   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_LOAD_SW = 4'd1;
   localparam logic [3:0] S_SEND_SW = 4'd2;
   localparam logic [3:0] S_WAIT_SW = 4'd3;
   localparam logic [3:0] S_RD_MEM  = 4'd4;
   localparam logic [3:0] S_LOAD_DW = 4'd5;
   localparam logic [3:0] S_SEND_DW = 4'd6;
   localparam logic [3:0] S_WAIT_DW = 4'd7;
   localparam logic [3:0] S_DONE    = 4'd8;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   logic [3:0]  state_q,       state_d;
   logic [5:0]  n_q,           n_d;           // words to send, 1..32
   logic        err_q,         err_d;         // message-error flag for status
   logic [5:0]  words_sent_q,  words_sent_d;
   logic        timeout_err_q, timeout_err_d;
   logic        busy_q,        busy_d;
   logic [15:0] tx_data_q,     tx_data_d;
   logic        tx_cd_q,       tx_cd_d;
   logic        tx_ready_q,    tx_ready_d;
   logic [15:0] wait_cnt_q,    wait_cnt_d;

   // Only the word-count field of the command word matters here; the rest
   // (address, T/R bit, subaddress) was already qualified by the decoder.
   logic        unused_cmd_bits;
   assign unused_cmd_bits = ^cmd_word[15:5];

   // -------------------------------------------------------------------------
   // Data buffer: 32x16, host writes in any state, registered read.
   // Read and write in the same cycle to the same address return the old
   // word, which is the natural behaviour of a read-before-write block RAM.
   // -------------------------------------------------------------------------
   logic [15:0] mem [0:31];
   logic [15:0] rd_data_q;
   logic [4:0]  rd_addr;
   logic        rd_en;

   // words_sent never exceeds 31 while a read is pending (n <= 32), so the
   // low five bits are always a valid buffer address.
   assign rd_addr = words_sent_q[4:0];
   assign rd_en   = (state_q == S_RD_MEM);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   logic [15:0] status_word;
   logic [15:0] wait_cnt_inc;
   logic [5:0]  words_sent_inc;
   logic        wait_expired;

   assign status_word    = {ADDRESS, err_q, 10'd0};
   assign wait_cnt_inc   = wait_cnt_q + 16'd1;
   assign words_sent_inc = words_sent_q + 6'd1;
   // The counter holds the number of edges already spent waiting; this edge
   // is the TIMEOUT-th one when the incremented value reaches TIMEOUT.
   assign wait_expired   = (wait_cnt_inc == TIMEOUT);

   always_comb begin
      state_d       = state_q;
      n_d           = n_q;
      err_d         = err_q;
      words_sent_d  = words_sent_q;
      timeout_err_d = timeout_err_q;
      busy_d        = busy_q;
      tx_data_d     = tx_data_q;
      tx_cd_d       = tx_cd_q;
      tx_ready_d    = 1'b0;              // strobe, high for one cycle only
      wait_cnt_d    = wait_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d           = (cmd_word[4:0] == 5'd0) ? 6'd32 : {1'b0, cmd_word[4:0]};
               err_d         = p_error;
               words_sent_d  = 6'd0;
               timeout_err_d = 1'b0;
               busy_d        = 1'b1;
               state_d       = S_LOAD_SW;
            end
         end

         S_LOAD_SW: begin
            tx_data_d = status_word;
            tx_cd_d   = 1'b0;
            state_d   = S_SEND_SW;
         end

         S_SEND_SW: begin
            tx_ready_d = 1'b1;
            wait_cnt_d = 16'd0;
            state_d    = S_WAIT_SW;
         end

         S_WAIT_SW: begin
            // tx_done is tested first so it wins over an expiring timeout.
            // n is never 0, so an error-free response always has data.
            if (tx_done) begin
               state_d = err_q ? S_DONE : S_RD_MEM;
            end else if (wait_expired) begin
               timeout_err_d = 1'b1;
               state_d       = S_DONE;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end

         S_RD_MEM: begin
            state_d = S_LOAD_DW;
         end

         S_LOAD_DW: begin
            tx_data_d = rd_data_q;
            tx_cd_d   = 1'b1;
            state_d   = S_SEND_DW;
         end

         S_SEND_DW: begin
            tx_ready_d = 1'b1;
            wait_cnt_d = 16'd0;
            state_d    = S_WAIT_DW;
         end

         S_WAIT_DW: begin
            if (tx_done) begin
               words_sent_d = words_sent_inc;
               state_d      = (words_sent_inc == n_q) ? S_DONE : S_RD_MEM;
            end else if (wait_expired) begin
               // words_sent keeps the count completed before the stall
               timeout_err_d = 1'b1;
               state_d       = S_DONE;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end

         S_DONE: begin
            busy_d  = 1'b0;
            tx_cd_d = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         n_q           <= 6'd0;
         err_q         <= 1'b0;
         words_sent_q  <= 6'd0;
         timeout_err_q <= 1'b0;
         busy_q        <= 1'b0;
         tx_data_q     <= 16'd0;
         tx_cd_q       <= 1'b0;
         tx_ready_q    <= 1'b0;
         wait_cnt_q    <= 16'd0;
      end else begin
         state_q       <= state_d;
         n_q           <= n_d;
         err_q         <= err_d;
         words_sent_q  <= words_sent_d;
         timeout_err_q <= timeout_err_d;
         busy_q        <= busy_d;
         tx_data_q     <= tx_data_d;
         tx_cd_q       <= tx_cd_d;
         tx_ready_q    <= tx_ready_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs come straight from registers
   // -------------------------------------------------------------------------
   assign tx_data     = tx_data_q;
   assign tx_cd       = tx_cd_q;
   assign tx_ready    = tx_ready_q;
   assign busy        = busy_q;
   assign words_sent  = words_sent_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: doc/rt_tx_responder.md
# rt_tx_responder

Remote-terminal transmit responder for the MKIO (GOST 26765.52) channel. It is the RT→BC counterpart of the terminal's receive path. When the command decoder flags a transmit command for this terminal, the block sends the status word followed by N data words to the Manchester encoder, one word per encoder handshake. The data words come from an internal 32×16 buffer that the host fills. The block sits between the command decoder, the host write port and the channel encoder.

## Interface
- ADDRESS, 5'd1, terminal address placed in status word bits [15:11]
- TIMEOUT, 16'd2000, max clk cycles to wait for encoder tx_done per word
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse: transmit command for this terminal decoded
- cmd_word  in  16  command word, valid while start=1; [4:0] = word count, 0 means 32
- p_error  in  1  parity error on the command word, valid while start=1
- tx_data  out  16  word to encoder
- tx_cd  out  1  sync type: 0 = status/command sync, 1 = data sync
- tx_ready  out  1  one-cycle strobe: tx_data/tx_cd valid, encoder to start sending
- tx_done  in  1  one-cycle pulse from encoder: current word fully sent
- wr_en  in  1  host buffer write enable
- wr_addr  in  5  host buffer write address
- wr_data  in  16  host buffer write data
- busy  out  1  response in progress
- words_sent  out  6  data words sent in current/last response
- timeout_err  out  1  sticky: encoder did not answer within TIMEOUT; cleared by next accepted start

## Operation
- Reset: tx_data=0, tx_cd=0, tx_ready=0, busy=0, words_sent=0, timeout_err=0, state IDLE. Reset in the middle of a response aborts it immediately. Buffer contents are not cleared.
- Buffer: 32×16 dual-port RAM on clk.
  - Synchronous write when wr_en=1, accepted in any state.
  - Synchronous read, 1-cycle latency.
  - Read and write to the same address in the same cycle returns the old data.
- start is sampled at a clk edge and is only accepted in IDLE; start while busy is ignored.
- On accept, latch the following:
  - n = (cmd_word[4:0]==0) ? 32 : cmd_word[4:0], held in a 6-bit register
  - err = p_error
  - Also clear words_sent and timeout_err.
- Status word = {ADDRESS, err, 10'd0}. Bit 10 is the message-error flag.
- If err=1, send the status word only, with no data words.
- Data words are read from buffer addresses 0..n-1 in order. The address never wraps, because n ≤ 32.
- States:
  - IDLE: tx_ready=0, busy=0. Goes to LOAD_SW on start.
  - LOAD_SW: tx_data=status, tx_cd=0, busy=1. Goes to SEND_SW.
  - SEND_SW: tx_ready=1 for this cycle only. Goes to WAIT_SW.
  - WAIT_SW: on tx_done, go to DONE if err or n==0 remaining, else go to RD_MEM.
  - RD_MEM: present rd_addr=words_sent[4:0]. Goes to LOAD_DW.
  - LOAD_DW: tx_data=RAM q, tx_cd=1. Goes to SEND_DW.
  - SEND_DW: tx_ready=1 for one cycle. Goes to WAIT_DW.
  - WAIT_DW: on tx_done, words_sent+1; go to DONE if words_sent+1==n, else go to RD_MEM.
  - DONE: busy=0, tx_cd=0. Goes to IDLE.
- Timeout:
  - A 16-bit wait counter clears on entry to WAIT_SW/WAIT_DW and counts each cycle in those states.
  - If it reaches TIMEOUT without tx_done: set timeout_err=1 and go to DONE (busy=0).
  - words_sent holds the count completed before the timeout.
- tx_done outside the WAIT states is ignored.
- tx_data holds its last value between words and after DONE. It clears only on reset.

## Timing
- start at edge E0:
  - busy=1 after E0
  - tx_data=status after E1
  - tx_ready high during the cycle after E2
- tx_data/tx_cd are stable one cycle before tx_ready and remain stable until the next LOAD state.
- tx_done sampled at edge Ed (not the last word):
  - words_sent increments after Ed
  - RAM address presented after Ed
  - tx_data=new word after Ed+2
  - tx_ready high after Ed+3
  - Latency tx_done→next tx_ready = 3 cycles.
- Last tx_done at Ed: DONE after Ed, busy=0 after Ed+1, IDLE accepts a new start from edge Ed+2.
- tx_ready is never high for two consecutive cycles. There is at most one outstanding word.
- Timeout fires at the TIMEOUT-th edge spent in a WAIT state.
- Simultaneous tx_done and timeout on the same edge: tx_done wins.
- Simultaneous host write and read of the same address: old data is sent.

## Test plan
- Basic: host writes addresses 0..3 with 16'hA000+i; start with cmd_word[4:0]=4, p_error=0, ADDRESS=1; encoder model returns tx_done 20 cycles after each tx_ready → 5 tx_ready strobes.
  - Words: 16'h0800 (cd=0), then A000..A003 (cd=1).
  - words_sent=4, busy falls, timeout_err=0.
- Count 0 means 32: buffer holds 0..31 = i; cmd_word[4:0]=0 → 33 strobes; last data word = 31; words_sent=32.
- Parity error: start with p_error=1, count=5 → single word 16'h0C00 with cd=0; no data words; words_sent=0.
- Timeout: count=2; encoder answers the status word and the first data word, never the second → timeout_err=1 exactly TIMEOUT cycles after the third tx_ready; busy=0; words_sent=1. Next start clears timeout_err.
- Start while busy, and reset mid-response:
  - A second start during WAIT_DW is ignored; the sequence is unchanged.
  - Asserting reset during SEND_DW clears all outputs asynchronously.
  - A fresh start after reset replays correctly.
- Timing check: tx_done→tx_ready spacing is exactly 3 cycles. A host write to address k in the same cycle it is read sends the old value.
